// File: rtl/trng_ring_ctrl.sv
// trng_ring_ctrl: sequencer for the inverter-ring TRNG.
// Gates the ring, discards a warm-up window, packs sampled ring bits into
// words (first sampled bit lands in the MSB), runs a repetition-count health
// test and hands words to a consumer over valid/ready. Every output comes
// straight from a register, so there is no combinational path from raw_bit.
module trng_ring_ctrl #(
    parameter int WARMUP_CYCLES = 64,
    parameter int BYTE_BITS     = 8,
    parameter int REP_LIMIT     = 16,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 raw_bit,
    output logic                 ring_en,
    output logic [BYTE_BITS-1:0] rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 health_fail,
    input  logic                 clear_fail,
    output logic [CNT_W-1:0]     bytes_out
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BIT_W  = $clog2(BYTE_BITS + 1);
    localparam int RUN_W  = $clog2(REP_LIMIT + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_BITS - 1);
    localparam logic [RUN_W-1:0]  RUN_TRIP  = RUN_W'(REP_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    state_t               state_r,    state_s;
    logic [WARM_W-1:0]    warm_cnt_r, warm_cnt_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_s;
    logic [RUN_W-1:0]     run_cnt_r,  run_cnt_s;
    logic                 last_bit_r, last_bit_s;
    logic [BYTE_BITS-1:0] shreg_r,    shreg_s;
    logic [BYTE_BITS-1:0] data_r,     data_s;
    logic                 valid_r,    valid_s;
    logic                 fail_r,     fail_s;
    logic                 ring_r,     ring_s;
    logic [CNT_W-1:0]     bytes_r,    bytes_s;

    logic [RUN_W-1:0]     run_next_s;
    logic [BYTE_BITS-1:0] shifted_s;

    assign ring_en     = ring_r;
    assign rnd_data    = data_r;
    assign rnd_valid   = valid_r;
    assign health_fail = fail_r;
    assign bytes_out   = bytes_r;

    // Next-state and next-datapath values; every target gets a hold default first.
    always_comb begin
        state_s    = state_r;
        warm_cnt_s = warm_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        run_cnt_s  = run_cnt_r;
        last_bit_s = last_bit_r;
        shreg_s    = shreg_r;
        data_s     = data_r;
        valid_s    = valid_r;
        fail_s     = fail_r;
        bytes_s    = bytes_r;
        shifted_s  = {shreg_r[BYTE_BITS-2:0], raw_bit};

        // A run restarts on the first sample after warm-up or on a bit change.
        if ((run_cnt_r == {RUN_W{1'b0}}) || (raw_bit != last_bit_r)) begin
            run_next_s = RUN_W'(1);
        end else begin
            run_next_s = run_cnt_r + RUN_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s    = ST_WARMUP;
                    warm_cnt_s = {WARM_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (warm_cnt_r == WARM_LAST) begin
                    state_s   = ST_COLLECT;
                    bit_cnt_s = {BIT_W{1'b0}};
                    run_cnt_s = {RUN_W{1'b0}};
                end else begin
                    warm_cnt_s = warm_cnt_r + WARM_W'(1);
                end
            end
            ST_COLLECT: begin
                if (!en) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end else if (run_next_s == RUN_TRIP) begin
                    // Health failure beats a word completing on the same edge.
                    state_s = ST_FAIL;
                    fail_s  = 1'b1;
                    valid_s = 1'b0;
                end else begin
                    shreg_s    = shifted_s;
                    run_cnt_s  = run_next_s;
                    last_bit_s = raw_bit;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s   = ST_HOLD;
                        data_s    = shifted_s;
                        valid_s   = 1'b1;
                        bit_cnt_s = {BIT_W{1'b0}};
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // A transfer on the same edge as en dropping still counts.
                if (valid_r && rnd_ready) begin
                    bytes_s   = bytes_r + CNT_W'(1);
                    valid_s   = 1'b0;
                    state_s   = ST_COLLECT;
                    bit_cnt_s = {BIT_W{1'b0}};
                end else begin
                    state_s = ST_HOLD;
                end
                if (!en) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end else begin
                    valid_s = valid_s;
                end
            end
            ST_FAIL: begin
                if (clear_fail) begin
                    state_s = ST_IDLE;
                    fail_s  = 1'b0;
                end else begin
                    state_s = ST_FAIL;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase

        ring_s = (state_s == ST_WARMUP) || (state_s == ST_COLLECT) || (state_s == ST_HOLD);
    end

    // State and datapath registers with synchronous reset that aborts any activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            warm_cnt_r <= {WARM_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            run_cnt_r  <= {RUN_W{1'b0}};
            last_bit_r <= 1'b0;
            shreg_r    <= {BYTE_BITS{1'b0}};
            data_r     <= {BYTE_BITS{1'b0}};
            valid_r    <= 1'b0;
            fail_r     <= 1'b0;
            ring_r     <= 1'b0;
            bytes_r    <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            warm_cnt_r <= warm_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            run_cnt_r  <= run_cnt_s;
            last_bit_r <= last_bit_s;
            shreg_r    <= shreg_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            fail_r     <= fail_s;
            ring_r     <= ring_s;
            bytes_r    <= bytes_s;
        end
    end

endmodule

// File: tb/tb_trng_ring_ctrl.sv
// tb_trng_ring_ctrl: self-checking bench for trng_ring_ctrl with a 4-cycle
// warm-up. A second instance with a 4-bit byte counter shares all inputs and
// is used to observe counter wrap-around.
module tb_trng_ring_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, raw_bit, rnd_ready, clear_fail;
    logic        ring_en, rnd_valid, health_fail;
    logic [7:0]  rnd_data;
    logic [15:0] bytes_out;
    logic        ring_en_w, rnd_valid_w, health_fail_w;
    logic [7:0]  rnd_data_w;
    logic [3:0]  bytes_out_w;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_word;

    trng_ring_ctrl #(.WARMUP_CYCLES(4), .BYTE_BITS(8), .REP_LIMIT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .ring_en(ring_en),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail), .clear_fail(clear_fail), .bytes_out(bytes_out)
    );

    trng_ring_ctrl #(.WARMUP_CYCLES(4), .BYTE_BITS(8), .REP_LIMIT(16), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .raw_bit(raw_bit), .ring_en(ring_en_w),
        .rnd_data(rnd_data_w), .rnd_valid(rnd_valid_w), .rnd_ready(rnd_ready),
        .health_fail(health_fail_w), .clear_fail(clear_fail), .bytes_out(bytes_out_w)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; raw_bit = 1'b0; rnd_ready = 1'b0; clear_fail = 1'b0;
        tick;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; raw_bit = 1'b1; rnd_ready = 1'b1; clear_fail = 1'b0;
        tick;
        n_cmp++; if (ring_en !== 1'b0) begin n_bad++; $display("FAIL reset_ring_en got %b want 0", ring_en); end
        n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rnd_valid); end
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL reset_health got %b want 0", health_fail); end
        n_cmp++; if (rnd_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", rnd_data); end
        n_cmp++; if (bytes_out !== 16'd0) begin n_bad++; $display("FAIL reset_bytes got %0d want 0", bytes_out); end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        logic [7:0] pat;
        pat = 8'hB2;
        do_reset;
        en = 1'b1;
        exp_q.push_back(pat);
        for (int e = 1; e <= 13; e++) begin
            raw_bit = (e >= 6) ? pat[7 - (e - 6)] : 1'b0;
            tick;
            if (e == 12) begin
                n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early_valid got %b want 0", rnd_valid); end
            end
        end
        n_cmp++; if (rnd_valid !== 1'b1) begin n_bad++; $display("FAIL latency_valid got %b want 1", rnd_valid); end
        exp_word = exp_q.pop_front();
        n_cmp++; if (rnd_data !== exp_word) begin n_bad++; $display("FAIL latency_data got %h want %h", rnd_data, exp_word); end
        for (int k = 0; k < 3; k++) begin
            raw_bit = ~raw_bit;
            tick;
            n_cmp++; if ((rnd_data !== exp_word) || (rnd_valid !== 1'b1)) begin
                n_bad++; $display("FAIL hold_stable got %h/%b want %h/1", rnd_data, rnd_valid, exp_word);
            end
        end
        rnd_ready = 1'b1;
        tick;
        n_cmp++; if (bytes_out !== 16'd1) begin n_bad++; $display("FAIL latency_bytes got %0d want 1", bytes_out); end
        n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL latency_valid_clr got %b want 0", rnd_valid); end
    endtask

    task automatic test_throughput;
        logic [7:0] m;
        int         nb;
        logic       ring_ok;
        m = 8'h00; nb = 0; ring_ok = 1'b1;
        do_reset;
        en = 1'b1; rnd_ready = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            raw_bit = e[0];
            if ((e >= 6) && (((e - 6) % 9) < 8)) begin
                m = {m[6:0], raw_bit};
                nb++;
                if (nb == 8) begin
                    exp_q.push_back(m);
                    nb = 0;
                end
            end
            tick;
            if (ring_en !== 1'b1) ring_ok = 1'b0;
            if ((e >= 13) && (((e - 13) % 9) == 0)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL tput_queue_empty at edge %0d", e);
                end else begin
                    exp_word = exp_q.pop_front();
                    n_cmp++; if ((rnd_valid !== 1'b1) || (rnd_data !== exp_word)) begin
                        n_bad++; $display("FAIL tput_word edge %0d got %h/%b want %h/1", e, rnd_data, rnd_valid, exp_word);
                    end
                end
            end
        end
        n_cmp++; if (bytes_out !== 16'd110) begin n_bad++; $display("FAIL tput_bytes got %0d want 110", bytes_out); end
        n_cmp++; if (bytes_out_w !== 4'd14) begin n_bad++; $display("FAIL tput_bytes_w got %0d want 14", bytes_out_w); end
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL tput_health got %b want 0", health_fail); end
        n_cmp++; if (ring_ok !== 1'b1) begin n_bad++; $display("FAIL tput_ring_en got dropped want constant 1"); end
    endtask

    task automatic test_health;
        do_reset;
        en = 1'b1; rnd_ready = 1'b1; raw_bit = 1'b0;
        exp_q.push_back(8'h00);
        for (int e = 1; e <= 22; e++) begin
            tick;
            if (e == 13) begin
                exp_word = exp_q.pop_front();
                n_cmp++; if ((rnd_valid !== 1'b1) || (rnd_data !== exp_word)) begin
                    n_bad++; $display("FAIL health_first_word got %h/%b want %h/1", rnd_data, rnd_valid, exp_word);
                end
            end
            if (e == 21) begin
                n_cmp++; if ((health_fail !== 1'b0) || (ring_en !== 1'b1)) begin
                    n_bad++; $display("FAIL health_early got fail=%b ring=%b want 0/1", health_fail, ring_en);
                end
            end
        end
        n_cmp++; if (health_fail !== 1'b1) begin n_bad++; $display("FAIL health_trip got %b want 1", health_fail); end
        n_cmp++; if (ring_en !== 1'b0) begin n_bad++; $display("FAIL health_ring got %b want 0", ring_en); end
        n_cmp++; if ((rnd_valid !== 1'b0) || (bytes_out !== 16'd1)) begin
            n_bad++; $display("FAIL health_no_word got valid=%b bytes=%0d want 0/1", rnd_valid, bytes_out);
        end
        for (int e = 23; e <= 25; e++) tick;
        n_cmp++; if ((health_fail !== 1'b1) || (ring_en !== 1'b0)) begin
            n_bad++; $display("FAIL health_sticky got fail=%b ring=%b want 1/0", health_fail, ring_en);
        end
        clear_fail = 1'b1;
        tick;
        clear_fail = 1'b0;
        n_cmp++; if ((health_fail !== 1'b0) || (ring_en !== 1'b0)) begin
            n_bad++; $display("FAIL health_clear got fail=%b ring=%b want 0/0", health_fail, ring_en);
        end
        raw_bit = 1'b1;
        tick;
        n_cmp++; if (ring_en !== 1'b1) begin n_bad++; $display("FAIL health_rewarm got %b want 1", ring_en); end
        for (int e = 28; e <= 38; e++) begin
            raw_bit = e[0];
            tick;
        end
        n_cmp++; if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL health_rewarm_early got %b want 0", rnd_valid); end
        raw_bit = 1'b1;
        tick;
        n_cmp++; if (rnd_valid !== 1'b1) begin n_bad++; $display("FAIL health_rewarm_valid got %b want 1", rnd_valid); end
    endtask

    task automatic test_en_drop;
        do_reset;
        en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            raw_bit = e[0];
            tick;
        end
        en = 1'b0; raw_bit = 1'b1;
        tick;
        n_cmp++; if ((ring_en !== 1'b0) || (rnd_valid !== 1'b0) || (bytes_out !== 16'd0)) begin
            n_bad++; $display("FAIL drop_collect got ring=%b valid=%b bytes=%0d want 0/0/0", ring_en, rnd_valid, bytes_out);
        end
        en = 1'b1;
        exp_q.push_back(8'hAA);
        for (int e = 10; e <= 22; e++) begin
            raw_bit = e[0];
            tick;
        end
        exp_word = exp_q.pop_front();
        n_cmp++; if ((rnd_valid !== 1'b1) || (rnd_data !== exp_word)) begin
            n_bad++; $display("FAIL drop_word got %h/%b want %h/1", rnd_data, rnd_valid, exp_word);
        end
        en = 1'b0; rnd_ready = 1'b1;
        tick;
        n_cmp++; if ((bytes_out !== 16'd1) || (rnd_valid !== 1'b0) || (ring_en !== 1'b0)) begin
            n_bad++; $display("FAIL drop_hold got bytes=%0d valid=%b ring=%b want 1/0/0", bytes_out, rnd_valid, ring_en);
        end
        rnd_ready = 1'b0;
        tick;
        n_cmp++; if ((ring_en !== 1'b0) || (bytes_out !== 16'd1)) begin
            n_bad++; $display("FAIL drop_idle got ring=%b bytes=%0d want 0/1", ring_en, bytes_out);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        do_reset;
        en = 1'b1; rnd_ready = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            if (e == 15) rnd_ready = 1'b0;
            raw_bit = e[0];
            tick;
        end
        n_cmp++; if ((rnd_valid !== 1'b1) || (bytes_out !== 16'd1)) begin
            n_bad++; $display("FAIL rst_pre_hold got valid=%b bytes=%0d want 1/1", rnd_valid, bytes_out);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if ({ring_en, rnd_valid, health_fail} !== 3'b000 || rnd_data !== 8'h00 || bytes_out !== 16'd0) begin
            n_bad++; $display("FAIL rst_in_hold got ring=%b valid=%b fail=%b data=%h bytes=%0d want all 0",
                              ring_en, rnd_valid, health_fail, rnd_data, bytes_out);
        end
        raw_bit = 1'b0; rnd_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick;
            if (health_fail === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_fail_timeout got no health_fail want 1 within 100 cycles"); end
        rst = 1'b1;
        tick;
        rst = 1'b0; en = 1'b0;
        n_cmp++; if ({ring_en, rnd_valid, health_fail} !== 3'b000 || rnd_data !== 8'h00 || bytes_out !== 16'd0) begin
            n_bad++; $display("FAIL rst_in_fail got ring=%b valid=%b fail=%b data=%h bytes=%0d want all 0",
                              ring_en, rnd_valid, health_fail, rnd_data, bytes_out);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        en = 1'b1; rnd_ready = 1'b1;
        for (int e = 1; e <= 148; e++) begin
            raw_bit = e[0];
            tick;
        end
        n_cmp++; if ((bytes_out_w !== 4'd15) || (bytes_out !== 16'd15)) begin
            n_bad++; $display("FAIL wrap_pre got %0d/%0d want 15/15", bytes_out_w, bytes_out);
        end
        raw_bit = 1'b1;
        tick;
        n_cmp++; if (bytes_out_w !== 4'd0) begin n_bad++; $display("FAIL wrap_zero got %0d want 0", bytes_out_w); end
        n_cmp++; if (bytes_out !== 16'd16) begin n_bad++; $display("FAIL wrap_wide got %0d want 16", bytes_out); end
    endtask

    // Test sequence.
    initial begin
        test_reset;
        test_latency;
        test_throughput;
        test_health;
        test_en_drop;
        test_reset_mid;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
